// File: rtl/alu_seq_unit.sv
// Handshaked ALU: single-cycle ADD/SUB/logic, iterative shift-add MUL and restoring DIV.
// Build option ALU_SEQ_MUL_EARLY_TERM_EN: MUL stops once the remaining multiplier bits are zero.
module alu_seq_unit #(
   parameter int unsigned WIDTH = 19
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Out,
   output logic             N,
   output logic             Z,
   output logic             V,
   output logic             C
);

   localparam int unsigned CntW = $clog2(WIDTH);

   localparam logic [3:0] OpAnd  = 4'b0000;
   localparam logic [3:0] OpOr   = 4'b0001;
   localparam logic [3:0] OpXor  = 4'b0010;
   localparam logic [3:0] OpPass = 4'b0011;
   localparam logic [3:0] OpAdd  = 4'b0100;
   localparam logic [3:0] OpSub  = 4'b0101;
   localparam logic [3:0] OpDiv  = 4'b0110;
   localparam logic [3:0] OpMul  = 4'b0111;

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic [WIDTH-1:0]     quo_q, quo_d;
   logic [WIDTH-1:0]     out_q, out_d;
   logic                 n_q, n_d, z_q, z_d, v_q, v_d, c_q, c_d;

   // Single-cycle datapath, evaluated on the live request operands
   logic [WIDTH:0]       sum, diff;
   logic [WIDTH-1:0]     sc_res;
   logic                 sc_c, sc_v;

   always_comb begin
      sum    = {1'b0, A} + {1'b0, B};
      diff   = {1'b0, A} - {1'b0, B};
      sc_res = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      case (sel)
         OpAnd:  sc_res = A & B;
         OpOr:   sc_res = A | B;
         OpXor:  sc_res = A ^ B;
         OpPass: sc_res = B;
         OpAdd: begin
            sc_res = sum[WIDTH-1:0];
            sc_c   = sum[WIDTH];
            sc_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OpSub: begin
            sc_res = diff[WIDTH-1:0];
            sc_c   = ~diff[WIDTH];
            sc_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         default: sc_res = '0;
      endcase
   end

   // One iteration of each multi-cycle algorithm
   logic [2*WIDTH-1:0]   prod_nxt;
   logic [WIDTH:0]       trial;
   logic [WIDTH-1:0]     rem_shift, rem_nxt, quo_nxt;
   logic                 cnt_last, mul_fin;

   always_comb begin
      prod_nxt  = prod_q + (b_q[0] ? mcand_q : '0);
      rem_shift = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      trial     = {rem_q, quo_q[WIDTH-1]} - {1'b0, b_q};
      rem_nxt   = trial[WIDTH] ? rem_shift : trial[WIDTH-1:0];
      quo_nxt   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
      cnt_last  = (cnt_q == CntW'(WIDTH - 1));
`ifdef ALU_SEQ_MUL_EARLY_TERM_EN
      mul_fin   = ((b_q >> 1) == '0);
`else
      mul_fin   = cnt_last;
`endif
   end

   logic                 load;
   logic [WIDTH-1:0]     res;
   logic                 res_c, res_v;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      prod_d    = prod_q;
      b_d       = b_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      load      = 1'b0;
      res       = '0;
      res_c     = 1'b0;
      res_v     = 1'b0;
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               b_d   = B;
               cnt_d = '0;
               if (sel == OpMul) begin
                  mcand_d = {{WIDTH{1'b0}}, A};
                  prod_d  = '0;
                  state_d = StMul;
               end else if (sel == OpDiv && B != '0) begin
                  rem_d   = '0;
                  quo_d   = A;
                  state_d = StDiv;
               end else if (sel == OpDiv) begin
                  load    = 1'b1;
                  res     = '1;
                  res_v   = 1'b1;
                  state_d = StDone;
               end else begin
                  load    = 1'b1;
                  res     = sc_res;
                  res_c   = sc_c;
                  res_v   = sc_v;
                  state_d = StDone;
               end
            end
         end
         StMul: begin
            mcand_d = mcand_q << 1;
            b_d     = b_q >> 1;
            prod_d  = prod_nxt;
            cnt_d   = cnt_q + CntW'(1);
            if (mul_fin) begin
               load    = 1'b1;
               res     = prod_nxt[WIDTH-1:0];
               res_c   = |prod_nxt[2*WIDTH-1:WIDTH];
               res_v   = |prod_nxt[2*WIDTH-1:WIDTH];
               state_d = StDone;
            end
         end
         StDiv: begin
            rem_d = rem_nxt;
            quo_d = quo_nxt;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_last) begin
               load    = 1'b1;
               res     = quo_nxt;
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      out_d = load ? res : out_q;
      n_d   = load ? res[WIDTH-1] : n_q;
      z_d   = load ? (res == '0) : z_q;
      v_d   = load ? res_v : v_q;
      c_d   = load ? res_c : c_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         out_q   <= '0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
         v_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         out_q   <= out_d;
         n_q     <= n_d;
         z_q     <= z_d;
         v_q     <= v_d;
         c_q     <= c_d;
      end
   end

   assign Out = out_q;
   assign N   = n_q;
   assign Z   = z_q;
   assign V   = v_q;
   assign C   = c_q;

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Sequential, handshaked execution unit for the vector datapath's ALU operation set.
- Accepts one operation (A, B, sel) over a valid/ready request channel and executes it.
- ADD, SUB and logic ops complete in one cycle; MUL and DIV iterate over several cycles.
- Returns the result and NZVC flags over a valid/ready response channel; it is the responder side of the ALU request interface that lane sequencers and benches drive.

Parameters:
- WIDTH, 19, operand/result width in bits (minimum 4).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- A  input  WIDTH  operand A, unsigned/two's complement per op.
- B  input  WIDTH  operand B.
- sel  input  4  operation select.
- out_valid  output  1  response valid.
- out_ready  input  1  consumer accepts the response.
- Out  output  WIDTH  result.
- N  output  1  negative flag.
- Z  output  1  zero flag.
- V  output  1  overflow flag.
- C  output  1  carry flag.

Behaviour:
- Interface: clk, rst; reset is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: in_ready=1; out_valid=0; Out=0; N=Z=V=C=0; FSM=IDLE.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE: in_ready=1. Request accepted when in_valid&&in_ready; A, B and sel are latched at acceptance.
  - Single-cycle ops (ADD, SUB, AND, OR, XOR, PASSB, reserved): next state DONE.
  - sel=0111: next state MUL.
  - sel=0110 with B!=0: next state DIV.
  - sel=0110 with B==0: next state DONE.
- MUL: shift-add multiply, one multiplier bit per cycle, WIDTH iterations, then DONE.
- DIV: restoring unsigned divide, one quotient bit per cycle, WIDTH iterations, then DONE.
- DONE: out_valid=1; Out and flags held stable. On out_ready=1 go to IDLE. in_ready=0 in DONE, so there is no accept in the same cycle.
- in_ready=0 in MUL, DIV and DONE; in_valid is ignored in those states.
- Latency from accept edge to out_valid: 1 cycle for single-cycle ops and divide-by-zero; WIDTH+1 cycles for MUL and DIV.
- Operations (sel):
  - 0100 ADD: A+B; C=carry out; V=signed overflow.
  - 0101 SUB: A-B; C=1 when A>=B unsigned (no borrow); V=signed overflow.
  - 0111 MUL: low WIDTH bits of unsigned A*B; C=V=1 when any high product bit is nonzero.
  - 0110 DIV: unsigned floor(A/B); C=V=0. If B==0: Out = all ones, V=1, C=0.
  - 0000 AND, 0001 OR, 0010 XOR, 0011 PASSB: C=V=0.
  - Any other code: Out=0, C=V=0.
- Flags for every op: N=Out[WIDTH-1], Z=(Out==0).
- Widths: all internal arithmetic uses WIDTH+1 bits for carry; product accumulator uses 2*WIDTH bits.
- Reset mid-operation (MUL, DIV or DONE): operation aborted, no response emitted, all outputs return to reset values on the next edge.
- Operand changes after acceptance have no effect.

Optional Feature:
- Macro: ALU_SEQ_MUL_EARLY_TERM_EN.
- Defined: MUL leaves the MUL state once all remaining unprocessed multiplier bits are zero, with a minimum of 1 iteration. Latency = (index of highest set bit of B)+2 cycles; B==0 gives 2 cycles.
- Not defined: MUL always runs WIDTH iterations.
- Result and flags are identical in both builds.

Test Plan:
- ADD A=3, B=1 accepted at edge t -> out_valid at t+1, Out=4, NZVC=0000; out_ready=1 -> in_ready=1 at t+2.
- SUB A=7, B=6 -> Out=1, C=1, N=Z=V=0; then SUB A=6, B=7 -> Out=19'h7FFFF, N=1, C=0, Z=0, V=0.
- MUL A=3, B=2 -> Out=6, NZVC=0000, out_valid at accept+20 (macro off) or accept+3 (macro on); MUL A=19'h40000, B=2 -> Out=0, Z=1, C=V=1.
- DIV A=4, B=2 -> Out=2, NZVC=0000, out_valid at accept+20; DIV A=5, B=0 -> Out=19'h7FFFF, V=1, N=1, out_valid at accept+1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> Out and flags stable, in_ready=0, a pulsed in_valid is not accepted; then out_ready=1 -> IDLE.
- Reset: assert rst 5 cycles into a DIV -> next edge out_valid=0, in_ready=1, Out=0, flags=0; a new ADD 1+1 then returns 2 normally.
